// File: rtl/sdram_ctrl.sv
// Single-command SDRAM controller: accepts one host request, issues it, then
// waits for the device's completion flag or a timeout before responding.
module sdram_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [14:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        cs,
  output logic        ras,
  output logic        cas,
  output logic        we,
  output logic [12:0] addr,
  output logic [1:0]  bank,
  inout  wire  [15:0] data,
  input  logic        ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [4:0] TIMEOUT_CNT = TIMEOUT[4:0];

  state_t      state, state_n;
  logic        cmd_n;
  logic        we_n;
  logic [12:0] addr_n;
  logic [1:0]  bank_n;
  logic [15:0] wdata_q, wdata_n;
  logic [4:0]  wait_cnt, wait_cnt_n, wait_cnt_inc;
  logic        rsp_valid_n, rsp_err_n;
  logic [15:0] rsp_rdata_n;
  logic        drive;

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign wait_cnt_inc = wait_cnt + 5'd1;

  // The bus is only ours while a write command is outstanding.
  assign drive = ((state == ISSUE) || (state == WAIT)) && we;
  assign data  = drive ? wdata_q : 16'hzzzz;

  // Next-state and next-register decode.
  always_comb begin
    state_n     = state;
    cmd_n       = cs;
    we_n        = we;
    addr_n      = addr;
    bank_n      = bank;
    wdata_n     = wdata_q;
    wait_cnt_n  = wait_cnt;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rsp_rdata_n = rsp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_n = ISSUE;
          cmd_n   = 1'b1;
          we_n    = req_we;
          bank_n  = req_addr[14:13];
          addr_n  = req_addr[12:0];
          wdata_n = req_wdata;
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        state_n    = WAIT;
        wait_cnt_n = 5'd0;
      end
      WAIT: begin
        // The count includes the current WAIT cycle, so the error fires after
        // exactly TIMEOUT WAIT cycles; ready on that same edge still wins.
        if (ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b1;
          cmd_n       = 1'b0;
          we_n        = 1'b0;
          addr_n      = 13'd0;
          bank_n      = 2'd0;
          wait_cnt_n  = 5'd0;
          if (!we) begin
            rsp_rdata_n = data;
          end else begin
            rsp_rdata_n = rsp_rdata;
          end
        end else if (wait_cnt_inc == TIMEOUT_CNT) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
          rsp_rdata_n = 16'd0;
          cmd_n       = 1'b0;
          we_n        = 1'b0;
          addr_n      = 13'd0;
          bank_n      = 2'd0;
          wait_cnt_n  = 5'd0;
        end else begin
          wait_cnt_n = wait_cnt_inc;
        end
      end
      default: begin
        state_n = IDLE;
        cmd_n   = 1'b0;
        we_n    = 1'b0;
        addr_n  = 13'd0;
        bank_n  = 2'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cs        <= 1'b0;
      ras       <= 1'b0;
      cas       <= 1'b0;
      we        <= 1'b0;
      addr      <= 13'd0;
      bank      <= 2'd0;
      wdata_q   <= 16'd0;
      wait_cnt  <= 5'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 16'd0;
    end else begin
      state     <= state_n;
      cs        <= cmd_n;
      ras       <= cmd_n;
      cas       <= cmd_n;
      we        <= we_n;
      addr      <= addr_n;
      bank      <= bank_n;
      wdata_q   <= wdata_n;
      wait_cnt  <= wait_cnt_n;
      rsp_valid <= rsp_valid_n;
      rsp_err   <= rsp_err_n;
      rsp_rdata <= rsp_rdata_n;
    end
  end

endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed self-checking bench for sdram_ctrl: write, read, back-to-back,
// timeout, ready/timeout coincidence and reset abort.
module tb_sdram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        cs, ras, cas, we;
  logic [12:0] addr;
  logic [1:0]  bank;
  wire  [15:0] data;
  logic        ready;
  logic        tb_en;
  logic [15:0] tb_val;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  // Responder / bus keeper: drives a known pattern whenever the controller
  // is expected to have released the bus.
  assign data = tb_en ? tb_val : 16'hzzzz;

  sdram_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .cs(cs), .ras(ras), .cas(cas), .we(we),
    .addr(addr), .bank(bank), .data(data), .ready(ready)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd_chk(input string tag, input logic on, input logic w,
                         input logic [1:0] b, input logic [12:0] a);
    chk({tag, "_cs"}, {15'd0, cs}, {15'd0, on});
    chk({tag, "_ras"}, {15'd0, ras}, {15'd0, on});
    chk({tag, "_cas"}, {15'd0, cas}, {15'd0, on});
    chk({tag, "_we"}, {15'd0, we}, {15'd0, w});
    chk({tag, "_bank"}, {14'd0, bank}, {14'd0, b});
    chk({tag, "_addr"}, {3'd0, addr}, {3'd0, a});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 15'd0;
    req_wdata = 16'd0; ready = 1'b0; tb_en = 1'b1; tb_val = 16'h1234;
    step(); step();
    cmd_chk("rst", 1'b0, 1'b0, 2'd0, 13'd0);
    chk("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    chk("rst_rsp_err", {15'd0, rsp_err}, 16'd0);
    chk("rst_rdata", rsp_rdata, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_req_ready", {15'd0, req_ready}, 16'd1);
    chk("rst_bus", data, 16'h1234);
    reset = 1'b0;
    step();

    // Write 0xBEEF to 0x2005, ready arrives for the first WAIT edge.
    tb_en = 1'b0; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 15'h2005; req_wdata = 16'hBEEF;
    chk("wr_req_ready", {15'd0, req_ready}, 16'd1);
    step();
    cmd_chk("wr_issue", 1'b1, 1'b1, 2'd1, 13'h0005);
    chk("wr_issue_data", data, 16'hBEEF);
    chk("wr_issue_busy", {15'd0, busy}, 16'd1);
    chk("wr_issue_rdy", {15'd0, req_ready}, 16'd0);
    chk("wr_issue_rv", {15'd0, rsp_valid}, 16'd0);
    req_valid = 1'b0; req_addr = 15'd0; req_wdata = 16'd0; ready = 1'b1;
    step();
    cmd_chk("wr_wait", 1'b1, 1'b1, 2'd1, 13'h0005);
    chk("wr_wait_data", data, 16'hBEEF);
    chk("wr_wait_rv", {15'd0, rsp_valid}, 16'd0);
    step();
    chk("wr_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    chk("wr_rsp_err", {15'd0, rsp_err}, 16'd0);
    chk("wr_rdata", rsp_rdata, 16'd0);
    chk("wr_done_busy", {15'd0, busy}, 16'd0);
    cmd_chk("wr_done", 1'b0, 1'b0, 2'd0, 13'd0);
    ready = 1'b0; tb_en = 1'b1; tb_val = 16'h1234;
    #1;
    chk("wr_done_bus", data, 16'h1234);
    step();
    chk("wr_pulse_end", {15'd0, rsp_valid}, 16'd0);

    // Read back 0xBEEF; wdata differs so any controller drive corrupts the bus.
    tb_val = 16'hBEEF; req_valid = 1'b1; req_we = 1'b0;
    req_addr = 15'h2005; req_wdata = 16'h4141;
    step();
    cmd_chk("rd_issue", 1'b1, 1'b0, 2'd1, 13'h0005);
    chk("rd_issue_bus", data, 16'hBEEF);
    req_valid = 1'b0;
    step();
    cmd_chk("rd_wait", 1'b1, 1'b0, 2'd1, 13'h0005);
    chk("rd_wait_bus", data, 16'hBEEF);
    ready = 1'b1;
    step();
    chk("rd_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    chk("rd_rsp_err", {15'd0, rsp_err}, 16'd0);
    chk("rd_rdata", rsp_rdata, 16'hBEEF);
    cmd_chk("rd_done", 1'b0, 1'b0, 2'd0, 13'd0);
    ready = 1'b0; tb_val = 16'h1234;
    step();
    chk("rd_pulse_end", {15'd0, rsp_valid}, 16'd0);
    chk("rd_rdata_hold", rsp_rdata, 16'hBEEF);

    // Back-to-back with req_valid and ready both held high.
    tb_en = 1'b0; ready = 1'b1; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 15'h4003; req_wdata = 16'h1111;
    step();
    cmd_chk("b2b1_issue", 1'b1, 1'b1, 2'd2, 13'h0003);
    chk("b2b1_data", data, 16'h1111);
    chk("b2b1_issue_rv", {15'd0, rsp_valid}, 16'd0);
    step();
    chk("b2b1_wait_rv", {15'd0, rsp_valid}, 16'd0);
    chk("b2b1_wait_cs", {15'd0, cs}, 16'd1);
    step();
    chk("b2b1_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    chk("b2b1_idle_cs", {15'd0, cs}, 16'd0);
    chk("b2b1_idle_rdy", {15'd0, req_ready}, 16'd1);
    chk("b2b1_rdata_keep", rsp_rdata, 16'hBEEF);
    req_we = 1'b0; req_addr = 15'h6007; req_wdata = 16'd0;
    tb_en = 1'b1; tb_val = 16'h5A5A;
    step();
    chk("b2b2_issue_rv", {15'd0, rsp_valid}, 16'd0);
    cmd_chk("b2b2_issue", 1'b1, 1'b0, 2'd3, 13'h0007);
    chk("b2b2_bus", data, 16'h5A5A);
    step();
    chk("b2b2_wait_rv", {15'd0, rsp_valid}, 16'd0);
    chk("b2b2_wait_cs", {15'd0, cs}, 16'd1);
    step();
    chk("b2b2_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    chk("b2b2_rdata", rsp_rdata, 16'h5A5A);
    chk("b2b2_rsp_err", {15'd0, rsp_err}, 16'd0);
    req_valid = 1'b0;
    step();
    chk("idle_ready_rv1", {15'd0, rsp_valid}, 16'd0);
    chk("idle_ready_busy", {15'd0, busy}, 16'd0);
    step();
    chk("idle_ready_rv2", {15'd0, rsp_valid}, 16'd0);
    chk("idle_ready_cs", {15'd0, cs}, 16'd0);
    ready = 1'b0;

    // Responder never answers: error after ISSUE plus 15 WAIT cycles.
    tb_val = 16'h1234; req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0010;
    step();
    cmd_chk("to_issue", 1'b1, 1'b0, 2'd0, 13'h0010);
    req_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("to_wait_rv", {15'd0, rsp_valid}, 16'd0);
      chk("to_wait_cs", {15'd0, cs}, 16'd1);
    end
    step();
    chk("to_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    chk("to_rsp_err", {15'd0, rsp_err}, 16'd1);
    chk("to_rdata", rsp_rdata, 16'd0);
    chk("to_busy", {15'd0, busy}, 16'd0);
    cmd_chk("to_done", 1'b0, 1'b0, 2'd0, 13'd0);
    step();
    chk("to_pulse_end", {15'd0, rsp_valid}, 16'd0);
    chk("to_err_end", {15'd0, rsp_err}, 16'd0);

    // ready arrives on the very edge the timeout would fire.
    tb_val = 16'h0F0F; req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0011;
    step();
    req_valid = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk("co_wait_rv", {15'd0, rsp_valid}, 16'd0);
    end
    step();
    chk("co_last_rv", {15'd0, rsp_valid}, 16'd0);
    ready = 1'b1;
    step();
    chk("co_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    chk("co_rsp_err", {15'd0, rsp_err}, 16'd0);
    chk("co_rdata", rsp_rdata, 16'h0F0F);
    ready = 1'b0;
    step();

    // Reset in the middle of a write's WAIT phase.
    tb_en = 1'b0; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 15'h2005; req_wdata = 16'hCAFE;
    step();
    req_valid = 1'b0;
    chk("ra_issue_data", data, 16'hCAFE);
    step();
    step();
    cmd_chk("ra_wait", 1'b1, 1'b1, 2'd1, 13'h0005);
    reset = 1'b1;
    step();
    cmd_chk("ra_abort", 1'b0, 1'b0, 2'd0, 13'd0);
    chk("ra_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    chk("ra_busy", {15'd0, busy}, 16'd0);
    chk("ra_rdata", rsp_rdata, 16'd0);
    tb_en = 1'b1; tb_val = 16'h1234;
    #1;
    chk("ra_bus", data, 16'h1234);
    reset = 1'b0;
    step();
    chk("ra_after_rv", {15'd0, rsp_valid}, 16'd0);
    tb_val = 16'h7777; req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h2005;
    step();
    req_valid = 1'b0;
    cmd_chk("ra_rd_issue", 1'b1, 1'b0, 2'd1, 13'h0005);
    step();
    ready = 1'b1;
    step();
    chk("ra_rd_rsp_valid", {15'd0, rsp_valid}, 16'd1);
    chk("ra_rd_rsp_err", {15'd0, rsp_err}, 16'd0);
    chk("ra_rd_rdata", rsp_rdata, 16'h7777);
    ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/sdram_ctrl.md
SDRAM_CTRL -- requirements
Module: sdram_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles in WAIT before an error response.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_we  input  1  1=write, 0=read.
REQ-007 req_addr  input  15  word address; [14:13]=bank, [12:0]=row/col.
REQ-008 req_wdata  input  16  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  16  read data; valid with rsp_valid on reads.
REQ-011 rsp_err  output  1  timeout flag; valid with rsp_valid.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 cs, ras, cas, we  output  1 each  SDRAM command strobes.
REQ-014 addr  output  13  SDRAM address.
REQ-015 bank  output  2  SDRAM bank.
REQ-016 data  inout  16  bidirectional SDRAM data bus.
REQ-017 ready  input  1  SDRAM command-complete flag.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT; all outputs SHALL be registered except req_ready and busy, which decode state.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid&&req_ready.
REQ-020 On acceptance: latch we, bank=req_addr[14:13], addr=req_addr[12:0], wdata; set cs=ras=cas=1; go to ISSUE.
REQ-021 ISSUE SHALL last exactly one cycle, SHALL ignore ready, then go to WAIT.
REQ-022 Command strobes, addr, bank, we SHALL be held constant through ISSUE and WAIT.
REQ-023 In WAIT, when ready=1 at an edge: for reads capture data into rsp_rdata; assert rsp_valid=1, rsp_err=0 for the next cycle; drop cs/ras/cas/we/addr/bank to 0; return to IDLE.
REQ-024 Nominal latency: accept edge E0 -> ready sampled at E2 -> rsp_valid high for the cycle after E2; next accept no earlier than E3.
REQ-025 data SHALL be driven with latched wdata only when state is ISSUE or WAIT and we=1; otherwise high-Z.
REQ-026 A 5-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ready.
REQ-027 When the counter equals TIMEOUT with ready=0: pulse rsp_valid with rsp_err=1, rsp_rdata=0, drop strobes, go to IDLE.
REQ-028 ready and timeout in the same cycle: ready wins (rsp_err=0).
REQ-029 rsp_rdata SHALL hold its last value between responses; writes SHALL not modify it.
REQ-030 req_valid while not in IDLE SHALL be ignored (no queuing); host must hold it.
REQ-031 ready=1 in IDLE or ISSUE SHALL have no effect.

Reset
REQ-032 Reset SHALL force IDLE; cs=ras=cas=we=0, addr=0, bank=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0, data high-Z.
REQ-033 Reset during ISSUE or WAIT SHALL abort the operation with no rsp_valid and release the bus on the next edge.

Verification
REQ-034 Write addr=0x2005 data=0xBEEF, responder asserts ready one edge after command -> cs/ras/cas/we=1, bank=1, addr=0x0005, data=0xBEEF for 2 cycles, rsp_valid 1 cycle, rsp_err=0.
REQ-035 Read same address, responder returns 0xBEEF -> data high-Z from controller, rsp_rdata=0xBEEF with rsp_valid, we=0 throughout.
REQ-036 Back-to-back requests with req_valid held -> second accepted no earlier than E3; no overlapping command; ready from first op not misread as completion of second.
REQ-037 Responder never asserts ready -> after ISSUE + 15 WAIT cycles rsp_valid=1, rsp_err=1, rsp_rdata=0; strobes return to 0.
REQ-038 Reset asserted in WAIT of a write -> next cycle all strobes 0, data high-Z, no rsp_valid; subsequent read completes normally.
REQ-039 ready held high in IDLE and coincident with timeout count -> no spurious response in IDLE; coincident case reports rsp_err=0.
